can_crc_seq: RTL

CAN_CRC_SEQ -- requirements
Module: can_crc_seq

---
 rtl/can_crc_seq.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/can_crc_seq.sv
// CAN CRC-15 sequencer: accumulates frame bits, then emits (TX) or checks (RX) the CRC field.
// Optional saturating RX CRC error counter enabled by defining CAN_CRC_ERRCNT_EN.
module can_crc_seq #(
  parameter int unsigned MAX_BITS = 83
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic        abort,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        bit_last,
  output logic        bit_ready,
  output logic        crc_bit,
  output logic        crc_valid,
  input  logic        crc_ready,
  output logic [14:0] crc_out,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic        len_err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned CntW = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {StIdle, StAccum, StTxCrc, StRxCrc, StDone} state_e;

  state_e          state;
  logic [14:0]     crc;
  logic [14:0]     crc_nxt;
  logic [14:0]     tx_sr;
  logic [CntW-1:0] bit_cnt;
  logic [3:0]      k;
  logic            mode_q;

  always_comb begin
    crc_nxt = {crc[13:0], 1'b0} ^ ((bit_in ^ crc[14]) ? 15'h4599 : 15'h0000);
  end

  assign bit_ready = (state == StAccum) || (state == StRxCrc);
  assign crc_valid = (state == StTxCrc);
  assign crc_bit   = (state == StTxCrc) & tx_sr[14];
  assign busy      = (state != StIdle);
  assign done      = (state == StDone);
  assign crc_out   = crc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      crc     <= '0;
      tx_sr   <= '0;
      bit_cnt <= '0;
      k       <= '0;
      mode_q  <= 1'b0;
      crc_ok  <= 1'b0;
      len_err <= 1'b0;
    end else if (abort) begin
      state   <= StIdle;
      k       <= '0;
      crc_ok  <= 1'b0;
      len_err <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            crc     <= '0;
            bit_cnt <= '0;
            k       <= '0;
            mode_q  <= mode;
            crc_ok  <= 1'b0;
            len_err <= 1'b0;
            state   <= StAccum;
          end
        end
        StAccum: begin
          if (bit_valid) begin
            crc     <= crc_nxt;
            bit_cnt <= bit_cnt + CntW'(1);
            if (bit_last) begin
              k <= '0;
              if (mode_q) begin
                state <= StRxCrc;
              end else begin
                // Snapshot the final CRC so crc_out stays visible while shifting out
                tx_sr <= crc_nxt;
                state <= StTxCrc;
              end
            end else if (bit_cnt == CntW'(MAX_BITS - 1)) begin
              len_err <= 1'b1;
              crc_ok  <= 1'b0;
              state   <= StDone;
            end
          end
        end
        StTxCrc: begin
          if (crc_ready) begin
            tx_sr <= {tx_sr[13:0], 1'b0};
            k     <= k + 4'd1;
            if (k == 4'd14) begin
              crc_ok <= 1'b1;
              state  <= StDone;
            end
          end
        end
        StRxCrc: begin
          if (bit_valid) begin
            crc <= crc_nxt;
            k   <= k + 4'd1;
            if (k == 4'd14) begin
              crc_ok <= (crc_nxt == 15'h0000);
              state  <= StDone;
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifdef CAN_CRC_ERRCNT_EN
  logic rx_fail;
  logic [7:0] err_cnt_q;

  assign rx_fail = !abort && (state == StRxCrc) && bit_valid && (k == 4'd14) &&
                   (crc_nxt != 15'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (rx_fail && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
